// File: rtl/matinv_result_streamer_if.sv
// Handshake bundle between the 5x5 matrix-inverse datapath, the result streamer and its consumer.
// master: the streamer side; slave: the inverter/consumer side.
interface matinv_result_streamer_if #(
    parameter int N  = 5,
    parameter int W  = 32,
    parameter int IW = 3
);
    logic [W*N*N-1:0] mat_in;
    logic             cap_valid;
    logic             cap_ready;
    logic [W-1:0]     out_data;
    logic [IW-1:0]    out_row;
    logic [IW-1:0]    out_col;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             frame_done;

    modport master (
        input  mat_in, cap_valid, out_ready,
        output cap_ready, out_data, out_row, out_col, out_last, out_valid, busy, frame_done
    );

    modport slave (
        output mat_in, cap_valid, out_ready,
        input  cap_ready, out_data, out_row, out_col, out_last, out_valid, busy, frame_done
    );
endinterface

// File: rtl/matinv_result_streamer.sv
// Captures a full N x N inverse result in one cycle and streams it row-major, one word per handshake.
// Optional macro MATINV_STREAM_CKSUM_EN appends an XOR checksum word (row N, col 0) to each frame.
module matinv_result_streamer #(
    parameter int N  = 5,
    parameter int W  = 32,
    parameter int IW = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matinv_result_streamer_if.master bus
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
`ifdef MATINV_STREAM_CKSUM_EN
        ,
        ST_CKSUM  = 2'd2
`endif
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [IW-1:0] row_reg;
    logic [IW-1:0] col_reg;
    logic          frame_done_reg;
    logic [W-1:0]  bank_reg [N][N];
    logic [W-1:0]  in_word  [N][N];

    logic          capture;
    logic          accept;
    logic          at_last;
    logic          frame_end;

    logic          cap_ready_c;
    logic          out_valid_c;
    logic          out_last_c;
    logic          busy_c;
    logic [W-1:0]  out_data_c;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                assign in_word[gi][gj] = bus.mat_in[W*(N*gi+gj) +: W];
            end
        end
    endgenerate

    assign capture = (state_reg == ST_IDLE) && bus.cap_valid;
    assign accept  = (state_reg != ST_IDLE) && bus.out_ready;
    assign at_last = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

`ifdef MATINV_STREAM_CKSUM_EN
    logic [W-1:0] cksum_reg;
    logic [W-1:0] cksum_next;

    always_comb begin
        cksum_next = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                cksum_next = cksum_next ^ in_word[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_reg <= '0;
        end else if (capture) begin
            cksum_reg <= cksum_next;
        end
    end

    assign frame_end = accept && (state_reg == ST_CKSUM);
`else
    assign frame_end = accept && (state_reg == ST_STREAM) && at_last;
`endif

    // Whole frame lands in one edge so the inverter can start its next solve immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    bank_reg[r][c] <= '0;
                end
            end
        end else if (capture) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    bank_reg[r][c] <= in_word[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.cap_valid) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (bus.out_ready && at_last) begin
`ifdef MATINV_STREAM_CKSUM_EN
                    state_next = ST_CKSUM;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef MATINV_STREAM_CKSUM_EN
            ST_CKSUM: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Separate row/column counters; the row wraps to 0 (or N for the checksum word) after the last column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg        <= '0;
            col_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= frame_end;
            if (capture) begin
                row_reg <= '0;
                col_reg <= '0;
            end else if (accept) begin
`ifdef MATINV_STREAM_CKSUM_EN
                if (state_reg == ST_CKSUM) begin
                    row_reg <= '0;
                    col_reg <= '0;
                end else
`endif
                if (col_reg == LAST_IDX) begin
                    col_reg <= '0;
                    if (row_reg == LAST_IDX) begin
`ifdef MATINV_STREAM_CKSUM_EN
                        row_reg <= IW'(N);
`else
                        row_reg <= '0;
`endif
                    end else begin
                        row_reg <= row_reg + IW'(1);
                    end
                end else begin
                    col_reg <= col_reg + IW'(1);
                end
            end
        end
    end

    always_comb begin
        cap_ready_c = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        busy_c      = 1'b0;
        out_data_c  = '0;
        case (state_reg)
            ST_IDLE: begin
                cap_ready_c = 1'b1;
            end
            ST_STREAM: begin
                out_valid_c = 1'b1;
                busy_c      = 1'b1;
                out_data_c  = bank_reg[row_reg][col_reg];
`ifndef MATINV_STREAM_CKSUM_EN
                out_last_c  = at_last;
`endif
            end
`ifdef MATINV_STREAM_CKSUM_EN
            ST_CKSUM: begin
                out_valid_c = 1'b1;
                busy_c      = 1'b1;
                out_last_c  = 1'b1;
                out_data_c  = cksum_reg;
            end
`endif
            default: begin
                cap_ready_c = 1'b0;
            end
        endcase
    end

    assign bus.cap_ready  = cap_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_last   = out_last_c;
    assign bus.busy       = busy_c;
    assign bus.out_data   = out_data_c;
    assign bus.out_row    = row_reg;
    assign bus.out_col    = col_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_matinv_result_streamer.sv
// Directed bench for matinv_result_streamer: basic frame, backpressure, capture blocking, reset, signed data.
module tb_matinv_result_streamer;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int IW = 3;
`ifdef MATINV_STREAM_CKSUM_EN
    localparam int FRAME_LEN = 26;
`else
    localparam int FRAME_LEN = 25;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matinv_result_streamer_if #(.N(N), .W(W), .IW(IW)) bus_if ();

    matinv_result_streamer #(.N(N), .W(W), .IW(IW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    logic [W*N*N-1:0] mat;
    logic [W*N*N-1:0] mat_ones;
    logic [31:0]      exp_word [0:25];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks_total++;
        if (got === expv) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    // kind 0: element(r,c)=16r+c; kind 1: all ones; kind 2: kind 0 with two negative entries
    task automatic set_frame(input int kind);
        logic [31:0] v;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                v = (kind == 1) ? 32'hFFFF_FFFF : 32'(16 * r + c);
                if (kind == 2 && r == 1 && c == 4) v = 32'hFFFF_FFF8;
                if (kind == 2 && r == 3 && c == 3) v = 32'hFFFF_FFF7;
                mat[W*(N*r+c) +: W] = v;
                exp_word[N*r+c]     = v;
            end
        end
        case (kind)
            0:       exp_word[25] = 32'h0000_0044;
            1:       exp_word[25] = 32'hFFFF_FFFF;
            default: exp_word[25] = 32'h0000_006C;
        endcase
    endtask

    task automatic do_capture();
        bus_if.mat_in    = mat;
        bus_if.cap_valid = 1'b1;
        check("cap_ready_idle", 32'(bus_if.cap_ready), 32'd1);
        check("valid_before_cap", 32'(bus_if.out_valid), 32'd0);
        @(posedge clk); #1;
        bus_if.cap_valid = 1'b0;
        check("busy_after_cap", 32'(bus_if.busy), 32'd1);
    endtask

    task automatic drain(input int take, input bit bp, input bit inject);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        while (k < take && cyc < 400) begin
            rdy = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            bus_if.out_ready = rdy;
            if (inject && k >= 10) begin
                bus_if.cap_valid = 1'b1;
                bus_if.mat_in    = mat_ones;
                check("cap_ready_busy", 32'(bus_if.cap_ready), 32'd0);
            end
            check("out_valid", 32'(bus_if.out_valid), 32'd1);
            check("out_data", bus_if.out_data, exp_word[k]);
            check("out_row", 32'(bus_if.out_row), (k < 25) ? 32'(k / 5) : 32'd5);
            check("out_col", 32'(bus_if.out_col), (k < 25) ? 32'(k % 5) : 32'd0);
            check("out_last", 32'(bus_if.out_last), (k == FRAME_LEN - 1) ? 32'd1 : 32'd0);
            if (rdy) begin
                $display("word %0d row %0d col %0d data 0x%08h last %0b",
                         k, bus_if.out_row, bus_if.out_col, bus_if.out_data, bus_if.out_last);
            end
            @(posedge clk); #1;
            if (rdy) k++;
            cyc++;
        end
        if (k < take) check("drain_timeout", 32'(k), 32'(take));
        bus_if.out_ready = 1'b0;
        bus_if.cap_valid = 1'b0;
        if (take == FRAME_LEN) begin
            check("frame_done_pulse", 32'(bus_if.frame_done), 32'd1);
            check("busy_end", 32'(bus_if.busy), 32'd0);
            check("cap_ready_end", 32'(bus_if.cap_ready), 32'd1);
            check("valid_end", 32'(bus_if.out_valid), 32'd0);
            @(posedge clk); #1;
            check("frame_done_clear", 32'(bus_if.frame_done), 32'd0);
        end
    endtask

    initial begin
        mat_ones          = '1;
        mat               = '0;
        bus_if.mat_in     = '0;
        bus_if.cap_valid  = 1'b0;
        bus_if.out_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cap_ready", 32'(bus_if.cap_ready), 32'd1);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_last", 32'(bus_if.out_last), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_frame_done", 32'(bus_if.frame_done), 32'd0);
        check("rst_out_data", bus_if.out_data, 32'd0);
        check("rst_out_row", 32'(bus_if.out_row), 32'd0);
        check("rst_out_col", 32'(bus_if.out_col), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready without a frame must not start anything
        bus_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready_valid", 32'(bus_if.out_valid), 32'd0);
        check("idle_ready_busy", 32'(bus_if.busy), 32'd0);
        bus_if.out_ready = 1'b0;

        $display("basic frame");
        set_frame(0);
        do_capture();
        drain(FRAME_LEN, 1'b0, 1'b0);

        $display("backpressure frame");
        set_frame(0);
        do_capture();
        drain(FRAME_LEN, 1'b1, 1'b0);

        $display("capture blocking");
        set_frame(0);
        do_capture();
        drain(FRAME_LEN, 1'b0, 1'b1);
        set_frame(1);
        do_capture();
        drain(FRAME_LEN, 1'b0, 1'b0);

        $display("reset mid-stream");
        set_frame(0);
        do_capture();
        drain(8, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("arst_busy", 32'(bus_if.busy), 32'd0);
        check("arst_cap_ready", 32'(bus_if.cap_ready), 32'd1);
        check("arst_out_data", bus_if.out_data, 32'd0);
        check("arst_out_row", 32'(bus_if.out_row), 32'd0);
        check("arst_out_col", 32'(bus_if.out_col), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("signed data after reset");
        set_frame(2);
        do_capture();
        drain(FRAME_LEN, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
